// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one async-read, single-write-port RAM between a CPU and a HOST requester
//   clk, reset                         clock and asynchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_ack   CPU request and one-cycle completion pulse, cpu_rdata read result
//   host_req/we/addr/wdata -> host_ack HOST request and completion pulse, host_rdata read result
//   host_lock                          HOST wins contested slots, bounded by LOCK_MAX
//   ram_we/r_addr/w_addr/w_data        drive the RAM during the ACC cycle, ram_r_data is its async read
//   busy                               high while an access occupies its ACC cycle
module ram_port_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int LOCK_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   input  logic          host_lock,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_r_addr,
   output logic [AW-1:0] ram_w_addr,
   output logic [DW-1:0] ram_w_data,
   input  logic [DW-1:0] ram_r_data,
   output logic          busy
);
   typedef enum logic {IDLE, ACC} state_t;
   state_t          state;
   logic            owner;
   logic            last;
   logic            cmd_we;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [7:0]      lock_cnt;
   logic            cpu_ok, host_ok, contest, force_cpu, grant, grant_host;
   // owner/last: 1 = HOST, 0 = CPU; the port finishing its ACC cycle cannot be re-granted at that edge
   always_comb begin
      cpu_ok = cpu_req & ~(state == ACC & ~owner);
      host_ok = host_req & ~(state == ACC & owner);
      contest = host_lock & cpu_req & host_req;
      force_cpu = (LOCK_MAX != 0) && (lock_cnt == 8'(LOCK_MAX)) && cpu_ok;
      grant_host = contest ? (~force_cpu & host_ok) : (host_ok & (~cpu_ok | ~last));
      grant = contest ? (force_cpu | host_ok) : (cpu_ok | host_ok);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last <= 1'b1;
         cmd_we <= 1'b0;
         cmd_addr <= '0;
         cmd_wdata <= '0;
         lock_cnt <= '0;
         cpu_ack <= 1'b0;
         host_ack <= 1'b0;
         cpu_rdata <= '0;
         host_rdata <= '0;
      end else begin
         state <= grant ? ACC : IDLE;
         cpu_ack <= state == ACC & ~owner;
         host_ack <= state == ACC & owner;
         if (state == ACC && !cmd_we && !owner) cpu_rdata <= ram_r_data;
         if (state == ACC && !cmd_we && owner) host_rdata <= ram_r_data;
         if (grant) begin
            owner <= grant_host;
            last <= grant_host;
            cmd_we <= grant_host ? host_we : cpu_we;
            cmd_addr <= grant_host ? host_addr : cpu_addr;
            cmd_wdata <= grant_host ? host_wdata : cpu_wdata;
         end
         lock_cnt <= (!host_lock || (grant && !grant_host)) ? 8'd0 :
                     (contest && grant_host) ? lock_cnt + 8'd1 : lock_cnt;
      end
   end
   assign busy = state == ACC;
   assign ram_we = (state == ACC) & cmd_we;
   assign ram_r_addr = cmd_addr;
   assign ram_w_addr = cmd_addr;
   assign ram_w_data = cmd_wdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized scoreboard bench for ram_port_arbiter with a transaction-level reference model
module tb_ram_port_arbiter;
   localparam int LM = 4;
   typedef struct {logic we; logic [7:0] addr; logic [7:0] wdata;} txn_t;
   typedef struct {int due; logic we; logic [7:0] rdata;} exp_t;
   logic clk = 0, reset = 1, load = 1;
   logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
   logic [7:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
   logic cpu_ack, host_ack, ram_we, busy;
   logic [7:0] cpu_rdata, host_rdata, ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;
   logic z_cpu_ack, z_host_ack, z_ram_we, z_busy;
   logic [7:0] z_cpu_rdata, z_host_rdata, z_ram_r_addr, z_ram_w_addr, z_ram_w_data;
   logic [7:0] zero_data = 0;
   logic [7:0] mem [256];
   logic [7:0] mmem [256];
   txn_t cq[$], hq[$];
   exp_t ceq[$], heq[$];
   int acc = 0, mlast = 2, mcnt = 0, cyc = 0, cgap = 0, hgap = 0;
   bit gaps = 0, rlock = 0, count_z = 0, cdone = 0, hdone = 0;
   logic xb = 0, xwe = 0;
   logic [7:0] xaddr = 0, xdata = 0;
   int nvec = 0, nerr = 0, zc = 0, zh = 0;
   always #5 clk = ~clk;
   ram_port_arbiter #(.AW(8), .DW(8), .LOCK_MAX(LM)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_lock(host_lock), .host_ack(host_ack), .host_rdata(host_rdata),
      .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
      .ram_r_data(ram_r_data), .busy(busy));
   ram_port_arbiter #(.AW(8), .DW(8), .LOCK_MAX(0)) dut_nolimit (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_lock(host_lock), .host_ack(z_host_ack), .host_rdata(z_host_rdata),
      .ram_we(z_ram_we), .ram_r_addr(z_ram_r_addr), .ram_w_addr(z_ram_w_addr), .ram_w_data(z_ram_w_data),
      .ram_r_data(zero_data), .busy(z_busy));
   function automatic logic [7:0] init_val(input logic [7:0] a);
      return (a * 8'd7) ^ 8'h3C;
   endfunction
   function automatic txn_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction
   function automatic txn_t rnd();
      return mk(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // RAM instance behaviour: async read, write at the clock edge
   assign ram_r_data = mem[ram_r_addr];
   always @(posedge clk)
      if (load) for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      else if (ram_we) mem[ram_w_addr] <= ram_w_data;
   always @(negedge clk) if (count_z) begin
      zc += int'(z_cpu_ack);
      zh += int'(z_host_ack);
   end
   // Reference model: decides at each edge which pending request is served, in spec terms
   task automatic model_step();
      int g = 0;
      int old = acc;
      bit c = cpu_req, h = host_req;
      bit cw = c && old != 1, hw = h && old != 2;
      bit contested = host_lock && c && h;
      exp_t e;
      txn_t t;
      if (contested) begin
         if (LM != 0 && mcnt == LM && cw) g = 1;
         else if (hw) g = 2;
      end else if (cw && hw) g = (mlast == 1) ? 2 : 1;
      else if (cw) g = 1;
      else if (hw) g = 2;
      if (g == 1 || !host_lock) mcnt = 0;
      else if (g == 2 && contested) mcnt++;
      cdone = old == 1;
      hdone = old == 2;
      xb = g != 0;
      if (g != 0) begin
         mlast = g;
         t = (g == 1) ? cq[0] : hq[0];
         e.due = cyc + 1;
         e.we = t.we;
         e.rdata = mmem[t.addr];
         if (t.we) mmem[t.addr] = t.wdata;
         if (g == 1) ceq.push_back(e); else heq.push_back(e);
         xwe = t.we; xaddr = t.addr; xdata = t.wdata;
      end
      if (cdone) void'(cq.pop_front());
      if (hdone) void'(hq.pop_front());
      acc = g;
   endtask
   task automatic drive();
      if (cdone) cgap = gaps ? $urandom_range(0, 3) : 0; else if (cgap > 0) cgap--;
      if (hdone) hgap = gaps ? $urandom_range(0, 3) : 0; else if (hgap > 0) hgap--;
      cdone = 0; hdone = 0;
      cpu_req = cgap == 0 && cq.size() > 0;
      if (cpu_req) begin cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].wdata; end
      host_req = hgap == 0 && hq.size() > 0;
      if (host_req) begin host_we = hq[0].we; host_addr = hq[0].addr; host_wdata = hq[0].wdata; end
      if (rlock) host_lock = $urandom_range(0, 2) == 0;
   endtask
   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin acc = 0; mlast = 2; mcnt = 0; xb = 0; end
      else model_step();
      #1;
      drive();
   end
   // Monitor: per-cycle RAM-side checks and ack-driven scoreboard pops
   initial forever begin
      exp_t e;
      @(negedge clk);
      chk("busy", 64'(busy), 64'(xb));
      chk("ram_we", 64'(ram_we), 64'(xb & xwe));
      if (xb) chk("ram_addr", {ram_r_addr, ram_w_addr}, {xaddr, xaddr});
      if (xb && xwe) chk("ram_w_data", 64'(ram_w_data), 64'(xdata));
      if (cpu_ack) begin
         if (ceq.size() == 0) chk("cpu_ack_spurious", 64'(cpu_ack), 0);
         else begin
            e = ceq.pop_front();
            chk("cpu_ack_cycle", 64'(cyc), 64'(e.due));
            if (!e.we) chk("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
         end
      end else if (ceq.size() > 0 && ceq[0].due <= cyc) begin
         void'(ceq.pop_front());
         chk("cpu_ack_missing", 64'(cpu_ack), 1);
      end
      if (host_ack) begin
         if (heq.size() == 0) chk("host_ack_spurious", 64'(host_ack), 0);
         else begin
            e = heq.pop_front();
            chk("host_ack_cycle", 64'(cyc), 64'(e.due));
            if (!e.we) chk("host_rdata", 64'(host_rdata), 64'(e.rdata));
         end
      end else if (heq.size() > 0 && heq[0].due <= cyc) begin
         void'(heq.pop_front());
         chk("host_ack_missing", 64'(host_ack), 1);
      end
   end
   task automatic wait_idle();
      int n = 0;
      while ((cq.size() || hq.size() || ceq.size() || heq.size() || acc != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 5000) begin
         nvec++; nerr++;
         $display("FAIL drain_timeout: %0d cpu and %0d host transactions still pending", cq.size(), hq.size());
      end
      repeat (2) @(posedge clk);
   endtask
   initial begin
      logic [7:0] save;
      int n;
      for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i));
      cq.push_back(mk(1'b0, 8'h03, 8'h00));
      @(negedge clk);
      load = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {cpu_ack, host_ack, ram_we, busy, cpu_rdata, host_rdata, ram_r_addr, ram_w_addr, ram_w_data},
          64'd0);
      chk("reset_cpu_req_held", 64'(cpu_req), 1);
      reset = 0;
      wait_idle();
      hq.push_back(mk(1'b1, 8'h05, 8'hA5));
      wait_idle();
      cq.push_back(mk(1'b0, 8'h05, 8'h00));
      wait_idle();
      chk("cpu_read_after_host_write", 64'(cpu_rdata), 64'hA5);
      chk("ram_holds_write", 64'(mem[8'h05]), 64'hA5);
      for (int i = 0; i < 20; i++) begin cq.push_back(rnd()); hq.push_back(rnd()); end
      wait_idle();
      host_lock = 1;
      for (int i = 0; i < 20; i++) cq.push_back(rnd());
      for (int i = 0; i < 40; i++) hq.push_back(rnd());
      repeat (4) @(posedge clk);
      zc = 0; zh = 0; count_z = 1;
      n = 0;
      while (hq.size() > 2 && n < 2000) begin @(posedge clk); n++; end
      count_z = 0;
      chk("nolimit_cpu_acks_under_lock", 64'(zc), 0);
      chk("nolimit_host_served", 64'(zh > 10), 1);
      host_lock = 0;
      wait_idle();
      save = mem[8'h40];
      hq.push_back(mk(1'b1, 8'h40, ~save));
      n = 0;
      do begin @(posedge clk); #2; n++; end while (acc != 2 && n < 50);
      chk("host_write_granted", 64'(acc), 2);
      reset = 1;
      hq.delete(); heq.delete(); cq.delete(); ceq.delete();
      acc = 0; xb = 0; mlast = 2; mcnt = 0; cgap = 0; hgap = 0;
      cpu_req = 0; host_req = 0;
      mmem[8'h40] = save;
      @(negedge clk);
      chk("reset_abort_busy", 64'(busy), 0);
      @(negedge clk);
      reset = 0;
      chk("reset_abort_mem", 64'(mem[8'h40]), 64'(save));
      repeat (3) @(negedge clk);
      chk("reset_abort_no_ack", 64'(host_ack), 0);
      chk("reset_abort_idle", 64'(busy), 0);
      for (int i = 0; i < 256; i++) cq.push_back(mk(1'b0, 8'(i), 8'h00));
      wait_idle();
      gaps = 1; rlock = 1;
      for (int i = 0; i < 150; i++) begin cq.push_back(rnd()); hq.push_back(rnd()); end
      wait_idle();
      rlock = 0; gaps = 0; host_lock = 0;
      wait_idle();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish in time");
      $fatal(1, "timeout");
   end
endmodule
